// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: processor, NIC and DMEM signals around the data-memory arbiter.
// slave modport is the arbiter's view; master modport is the surrounding processor/NIC/DMEM.
// Buses are MSB-first ([0:N]).
interface dmem_arbiter_if;
  logic [0:7]  proc_addr;
  logic [0:63] proc_data_out;
  logic        proc_en;
  logic        proc_wr_en;
  logic [0:63] proc_data_in;
  logic        proc_stall;
  logic        nic_req;
  logic        nic_wr;
  logic [0:7]  nic_addr;
  logic [0:2]  nic_len;
  logic        nic_ack;
  logic [0:63] nic_wr_data;
  logic        nic_beat;
  logic [0:63] nic_rd_data;
  logic        nic_rd_valid;
  logic        nic_done;
  logic [0:7]  mem_addr;
  logic [0:63] mem_din;
  logic [0:63] mem_dout;
  logic        mem_en;
  logic        mem_wr_en;
  modport slave (
    input  proc_addr, proc_data_out, proc_en, proc_wr_en, nic_req, nic_wr, nic_addr, nic_len, nic_wr_data, mem_dout,
    output proc_data_in, proc_stall, nic_ack, nic_beat, nic_rd_data, nic_rd_valid, nic_done, mem_addr, mem_din, mem_en, mem_wr_en
  );
  modport master (
    output proc_addr, proc_data_out, proc_en, proc_wr_en, nic_req, nic_wr, nic_addr, nic_len, nic_wr_data, mem_dout,
    input  proc_data_in, proc_stall, nic_ack, nic_beat, nic_rd_data, nic_rd_valid, nic_done, mem_addr, mem_din, mem_en, mem_wr_en
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the DMEM port between the processor (fixed priority) and NIC bursts.
// Ports: clk, rst_n (async active-low), bus (dmem_arbiter_if.slave: processor, NIC and DMEM sides).
// STARVE_LIMIT (1..15): consecutive blocked NIC cycles before a one-cycle processor stall.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BURST = 2'd1, FINISH = 2'd2;
  logic [1:0] state;
  logic [0:7] addr_q;
  logic [0:2] rem_q;
  logic       wr_q;
  logic [0:3] starve_cnt;
  logic       nic_sel;
  logic       blocked;
  // A registered stall hands the port to the NIC for exactly one cycle.
  assign nic_sel = state == BURST && (!bus.proc_en || bus.proc_stall);
  assign blocked = state == BURST && bus.proc_en && !bus.proc_stall;
  assign bus.nic_beat     = nic_sel;
  assign bus.mem_en       = nic_sel || bus.proc_en;
  assign bus.mem_addr     = nic_sel ? addr_q : bus.proc_addr;
  assign bus.mem_wr_en    = nic_sel ? wr_q : bus.proc_wr_en;
  assign bus.mem_din      = nic_sel ? bus.nic_wr_data : bus.proc_data_out;
  assign bus.proc_data_in = bus.mem_dout;
  assign bus.nic_rd_data  = bus.mem_dout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      addr_q           <= '0;
      rem_q            <= '0;
      wr_q             <= 1'b0;
      starve_cnt       <= '0;
      bus.proc_stall   <= 1'b0;
      bus.nic_ack      <= 1'b0;
      bus.nic_rd_valid <= 1'b0;
      bus.nic_done     <= 1'b0;
    end else begin
      bus.nic_ack      <= state == IDLE && bus.nic_req;
      bus.nic_done     <= nic_sel && rem_q == 3'd0;
      bus.nic_rd_valid <= nic_sel && !wr_q;
      bus.proc_stall   <= blocked && starve_cnt == 4'(STARVE_LIMIT - 1);
      if (state == IDLE && bus.nic_req) begin
        addr_q     <= bus.nic_addr;
        rem_q      <= bus.nic_len;
        wr_q       <= bus.nic_wr;
        starve_cnt <= '0;
        state      <= BURST;
      end else if (nic_sel) begin
        addr_q     <= addr_q + 8'd1;
        starve_cnt <= '0;
        if (rem_q == 3'd0) state <= FINISH;
        else rem_q <= rem_q - 3'd1;
      end else if (blocked) begin
        starve_cnt <= starve_cnt + 4'd1;
      end else if (state != BURST) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed stimulus against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter_if bus();
  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [63:0] dmem [256];
  logic [63:0] shadow [256];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_wr_en) dmem[bus.mem_addr] <= bus.mem_din;
      else bus.mem_dout <= dmem[bus.mem_addr];
    end
  int n_chk = 0;
  int n_pass = 0;
  int ph, left, waits, len_q, beats_seen;
  logic [7:0] m_addr;
  bit m_wr, m_stall, m_ack, m_rdv, m_prv, hold;
  logic [63:0] m_rd, m_pd;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model_reset();
    ph = 0; left = 0; waits = 0; len_q = 0; beats_seen = 0;
    m_stall = 0; m_ack = 0; m_rdv = 0; m_prv = 0; hold = 0;
  endtask
  task automatic cycle(bit req, bit wr, logic [7:0] a, logic [2:0] len, bit pen, bit pwr);
    bit beat, men, ew, nstall;
    logic [7:0] ea;
    logic [63:0] ed;
    @(posedge clk);
    #1;
    bus.nic_req = req;
    bus.nic_wr = wr;
    bus.nic_addr = a;
    bus.nic_len = len;
    bus.nic_wr_data = {$urandom, $urandom};
    if (!hold) begin
      bus.proc_en = pen;
      bus.proc_wr_en = pwr;
      bus.proc_addr = 8'($urandom);
      bus.proc_data_out = {$urandom, $urandom};
    end
    @(negedge clk);
    beat = ph == 1 && (!bus.proc_en || m_stall);
    men = beat || bus.proc_en;
    ea = beat ? m_addr : bus.proc_addr;
    ew = beat ? m_wr : bus.proc_wr_en;
    ed = beat ? bus.nic_wr_data : bus.proc_data_out;
    check("nic_beat", bus.nic_beat, beat);
    check("proc_stall", bus.proc_stall, m_stall);
    check("nic_ack", bus.nic_ack, m_ack);
    check("nic_done", bus.nic_done, ph == 2);
    check("nic_rd_valid", bus.nic_rd_valid, m_rdv);
    if (m_rdv) check("nic_rd_data", bus.nic_rd_data, m_rd);
    if (m_prv) check("proc_data_in", bus.proc_data_in, m_pd);
    check("mem_en", bus.mem_en, men);
    if (men) begin
      check("mem_addr", bus.mem_addr, ea);
      check("mem_wr_en", bus.mem_wr_en, ew);
      if (ew) check("mem_din", bus.mem_din, ed);
    end
    if (ph == 1 && bus.nic_beat) beats_seen++;
    if (ph == 2) check("beat_count", beats_seen, len_q + 1);
    m_ack = ph == 0 && bus.nic_req;
    m_rdv = beat && !m_wr;
    if (m_rdv) m_rd = shadow[m_addr];
    m_prv = !beat && bus.proc_en && !bus.proc_wr_en;
    if (m_prv) m_pd = shadow[bus.proc_addr];
    if (men && ew) shadow[ea] = ed;
    nstall = ph == 1 && bus.proc_en && !m_stall && waits == LIMIT - 1;
    hold = m_stall;
    if (ph == 0) begin
      if (bus.nic_req) begin
        m_addr = bus.nic_addr; len_q = int'(bus.nic_len); left = len_q + 1;
        m_wr = bus.nic_wr; waits = 0; beats_seen = 0; ph = 1;
      end
    end else if (ph == 1) begin
      if (beat) begin
        m_addr = m_addr + 8'd1; left--; waits = 0;
        if (left == 0) ph = 2;
      end else waits++;
    end else ph = 0;
    m_stall = nstall;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 3'd0, 0, 0);
  endtask
  initial begin
    logic [63:0] v;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      dmem[i] = v;
      shadow[i] = v;
    end
    bus.nic_req = 0; bus.nic_wr = 0; bus.nic_addr = '0; bus.nic_len = '0; bus.nic_wr_data = '0;
    bus.proc_en = 1; bus.proc_wr_en = 0; bus.proc_addr = 8'h33; bus.proc_data_out = '0;
    model_reset();
    #2;
    check("rst_stall", bus.proc_stall, 0);
    check("rst_ack", bus.nic_ack, 0);
    check("rst_beat", bus.nic_beat, 0);
    check("rst_rd_valid", bus.nic_rd_valid, 0);
    check("rst_done", bus.nic_done, 0);
    check("rst_mem_en", bus.mem_en, 1);
    check("rst_mem_addr", bus.mem_addr, 8'h33);
    bus.proc_en = 0;
    @(negedge clk);
    rst_n = 1;
    idle(2);
    cycle(1, 1, 8'h10, 3'd3, 0, 0);
    idle(6);
    cycle(1, 0, 8'hFE, 3'd2, 0, 0);
    idle(6);
    cycle(1, 0, 8'h40, 3'd1, 0, 0);
    cycle(0, 0, 8'h00, 3'd0, 1, 0);
    cycle(0, 0, 8'h00, 3'd0, 1, 1);
    idle(4);
    cycle(1, 0, 8'h50, 3'd0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 3'd0, 1, 0);
    idle(2);
    cycle(1, 1, 8'h60, 3'd3, 0, 0);
    cycle(1, 0, 8'h00, 3'd7, 0, 0);
    idle(6);
    cycle(1, 0, 8'h80, 3'd7, 0, 0);
    idle(2);
    @(posedge clk);
    #1;
    bus.proc_en = 1; bus.proc_wr_en = 0; bus.proc_addr = 8'h21;
    rst_n = 0;
    #1;
    check("midrst_beat", bus.nic_beat, 0);
    check("midrst_ack", bus.nic_ack, 0);
    check("midrst_rd_valid", bus.nic_rd_valid, 0);
    check("midrst_done", bus.nic_done, 0);
    check("midrst_stall", bus.proc_stall, 0);
    check("midrst_mem_en", bus.mem_en, 1);
    check("midrst_mem_addr", bus.mem_addr, 8'h21);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(2);
    cycle(1, 0, 8'h90, 3'd2, 0, 0);
    idle(6);
    for (int blk = 0; blk < 6; blk++)
      for (int i = 0; i < 500; i++)
        cycle($urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom), 3'($urandom),
              $urandom_range(0, 99) < 15 + blk * 16, 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the cardinal processor's load/store path and a NIC burst requester. The processor has fixed priority. NIC bursts are issued one beat per idle memory cycle. A starvation counter raises a one-cycle processor stall so the NIC is guaranteed progress. The block sits between the processor's Dmem port and the DMEM macro, and all bus bit-ordering is MSB-first ([0:N]).

## Interface
- STARVE_LIMIT, 4: consecutive blocked NIC cycles before Proc_Stall is forced; legal range 1..15.

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Proc_Addr  in  [0:7]  processor memory address
- Proc_Data_Out  in  [0:63]  processor store data
- Proc_En  in  1  processor memory access (load or store)
- Proc_WrEn  in  1  processor store
- Proc_Data_In  out  [0:63]  load data to processor; combinational copy of Mem_Dout
- Proc_Stall  out  1  registered; processor freezes and re-presents the same access next cycle
- Nic_Req  in  1  burst request, sampled in IDLE only
- Nic_Wr  in  1  1 = write burst, 0 = read burst
- Nic_Addr  in  [0:7]  burst start address
- Nic_Len  in  [0:2]  beats minus 1 (1..8 beats)
- Nic_Ack  out  1  one-cycle pulse: request latched
- Nic_Wr_Data  in  [0:63]  current write beat; must be valid whenever a write burst is active
- Nic_Beat  out  1  beat issued this cycle; on writes, Nic_Wr_Data is consumed
- Nic_Rd_Data  out  [0:63]  read beat data; combinational copy of Mem_Dout
- Nic_Rd_Valid  out  1  registered; Nic_Rd_Data is valid
- Nic_Done  out  1  one-cycle pulse, cycle after the last beat
- Mem_Addr  out  [0:7]  to DMEM
- Mem_Din  out  [0:63]  DMEM write data
- Mem_Dout  in  [0:63]  DMEM read data, one-cycle synchronous read
- Mem_En  out  1  DMEM enable
- Mem_WrEn  out  1  DMEM write enable

## Operation
- **State machine:** IDLE, BURST, FINISH.
- **IDLE:**
  - When Nic_Req=1: latch Nic_Addr into addr_q, Nic_Len into rem_q, and Nic_Wr into wr_q.
  - Pulse Nic_Ack, clear starve_cnt, go to BURST.
- **Port mux (combinational):**
  - nic_sel = (state==BURST) && (Proc_En==0 || Proc_Stall==1).
  - When nic_sel=1: Mem_* come from addr_q / wr_q / Nic_Wr_Data, and Mem_En=1.
  - Otherwise: Mem_* follow the Proc_* inputs.
  - Nic_Beat = nic_sel.
- **BURST, beat issued (nic_sel=1):**
  - addr_q increments with 8-bit wrap (0xFF -> 0x00).
  - starve_cnt is cleared.
  - If rem_q==0, go to FINISH; otherwise rem_q decrements.
- **BURST, blocked (Proc_En=1 and Proc_Stall=0):**
  - starve_cnt increments.
  - When starve_cnt reaches STARVE_LIMIT-1 on a blocked cycle, Proc_Stall is registered to 1 for the next cycle only, and the NIC beat is issued in that cycle.
- **Proc_Stall:** never asserted for two consecutive cycles; never asserted outside BURST.
- **FINISH:** pulse Nic_Done, go to IDLE. A new Nic_Req is accepted only in the following IDLE cycle.
- **Nic_Req outside IDLE:** ignored; not queued.
- **Nic_Rd_Valid:** registered copy of (nic_sel && !wr_q).
- **Processor access during IDLE or FINISH:** passes straight through with zero added latency.
- **Reset:** asynchronously clears state to IDLE and clears addr_q, rem_q, wr_q, starve_cnt, Proc_Stall, Nic_Ack, Nic_Rd_Valid and Nic_Done. A burst in flight is abandoned: no Nic_Done and no further beats.

## Timing
- Output values while Reset is asserted:
  - Proc_Stall, Nic_Ack, Nic_Beat, Nic_Rd_Valid, Nic_Done = 0.
  - Mem_En = Proc_En (pass-through, since the state is IDLE).
- Request to first beat:
  - Nic_Req sampled at edge T; Nic_Ack is high in cycle T+1, which is also the first cycle in BURST.
  - First beat issues in cycle T+1 if the port is free.
- An unblocked N-beat burst occupies cycles T+1..T+N. Nic_Done is high in T+N+1; the next Nic_Req is sampled no earlier than edge T+N+2.
- Read latency: Nic_Rd_Valid is high exactly one cycle after each read Nic_Beat. The last Nic_Rd_Valid coincides with Nic_Done.
- Worst-case NIC wait per beat: STARVE_LIMIT blocked cycles plus one stall cycle.

## Test plan
- **Reset mid-burst:** drop Reset during beat 3 of an 8-beat read.
  - All NIC outputs are 0 and the state is IDLE; the processor passes through.
  - A new request restarts cleanly.
- **Idle write burst:** Nic_Addr=0x10, Nic_Len=3, Nic_Wr=1, Proc_En=0.
  - Nic_Ack in T+1; Mem_WrEn beats at 0x10..0x13 in T+1..T+4; Nic_Done in T+5.
- **Read burst with wrap:** Nic_Addr=0xFE, Nic_Len=2, memory preloaded.
  - Addresses issued are 0xFE, 0xFF, 0x00.
  - Three Nic_Rd_Valid pulses, each one cycle after its beat, with matching data.
- **Processor priority:** Proc_En=1 for 2 cycles during a 2-beat NIC burst.
  - Processor accesses reach DMEM unaltered; NIC beats are deferred 2 cycles; Proc_Stall stays 0.
- **Starvation:** STARVE_LIMIT=4, Proc_En held at 1 during a 1-beat read.
  - Proc_Stall is high for exactly one cycle after 4 blocked cycles; the NIC beat issues in that cycle.
  - The processor access re-presented in the next cycle completes; Nic_Done follows.
- **Request ignored outside IDLE:** pulse Nic_Req while in BURST.
  - No second Nic_Ack; beat count equals the original Nic_Len+1.
